alu_cmd_sequencer: RTL and testbench
====================================

// Module: alu_cmd_sequencer
// PURPOSE
//  Command front-end for the 8-bit alu. Accepts {op,a,b,chain} commands on a valid/ready
//  interface and buffers them in a FIFO. Issues one command at a time to the
//  combinational alu and registers its 16-bit result onto a valid/ready output.
//  Chain mode feeds the previous result's low byte back as operand a.
// PARAMETERS
//  DEPTH   4   command FIFO entries; power of 2, >= 2
// PORTS
//  clk         in   1   single clock, rising edge
//  rst_n       in   1   asynchronous, active-low reset
//  in_valid    in   1   upstream command valid
//  in_ready    out  1   sequencer can accept a command (= !fifo_full)
//  in_op       in   2   alu_pkg::opcode_e (ADD/SUB/MUL/XOR)
//  in_a        in   8   operand a (ignored when in_chain=1)
//  in_b        in   8   operand b
//  in_chain    in   1   1: use last_result[7:0] as operand a
//  alu_a       out  8   registered operand to alu.a
//  alu_b       out  8   registered operand to alu.b
//  alu_op      out  2   registered opcode to alu.op
//  alu_result  in   16  combinational result from alu
//  out_valid   out  1   result valid
//  out_ready   in   1   downstream accepts result
//  out_data    out  16  registered result
//  out_op      out  2   opcode that produced out_data
//  busy        out  1   FIFO non-empty or state != IDLE
// BEHAVIOUR
//  Reset (async, rst_n=0): FIFO empty; state=IDLE; alu_a/alu_b=0; alu_op=ADD;
//   out_valid=0; out_data=0; out_op=ADD; last_result=0; busy=0; in_ready=1.
//  Reset mid-operation: in-flight and queued commands are discarded. No result is emitted.
//  Input: push on in_valid&&in_ready. in_ready=!full only; a same-cycle pop does not
//   free space for a push when full. Pointers wrap mod DEPTH; count 0..DEPTH.
//  FSM: IDLE, EXEC, HOLD.
//   IDLE: FIFO non-empty -> pop head, register alu_a/b/op -> EXEC.
//   EXEC: out_data<=alu_result, out_op<=alu_op, last_result<=alu_result,
//         out_valid<=1 -> HOLD.
//   HOLD: out_valid&&out_ready -> out_valid<=0; FIFO non-empty -> pop next
//         command into alu_* regs and go to EXEC (no IDLE bubble). Otherwise -> IDLE.
//         out_data/out_op stay stable while out_valid&&!out_ready.
//  Chain: alu_a <= in_chain ? last_result[7:0] : a. This is resolved at pop time, so it
//   uses the result captured in the immediately preceding EXEC.
//  Latency: accept at edge N into an empty idle block -> out_valid high after edge N+2.
//   Sustained throughput: 1 result per 2 cycles with out_ready=1.
//  Width: alu_result is taken as-is at 16 bits. SUB underflow wraps in 16 bits;
//   MUL is the full 16-bit product.
//  Capacity under backpressure: DEPTH queued + 1 in EXEC/HOLD.
// STRUCTURE
//  alu_pkg (shared, existing): opcode_e. Adds:
//   typedef struct packed {opcode_e op; logic [7:0] a,b; logic chain;} alu_cmd_t;
//   typedef enum logic [1:0] {SEQ_IDLE, SEQ_EXEC, SEQ_HOLD} seq_state_e;
//  Sub-module alu_cmd_fifo #(DEPTH, alu_cmd_t): sync FIFO with push/pop/full/empty/
//   count and the same clk/rst_n. The alu itself is instantiated by the parent,
//   not inside this block.
// TESTING (bench instantiates alu_cmd_sequencer + alu)
//  1 Reset: rst_n=0 -> in_ready=1, out_valid=0, out_data=0, busy=0.
//  2 ADD a=200 b=100, out_ready=1 -> out_valid 2 cycles after accept,
//    out_data=16'h012C, out_op=ADD.
//  3 SUB 5-10 -> 16'hFFFB; MUL 255*255 -> 16'hFE01; XOR 8'hA5^8'h0F -> 16'h00AA.
//  4 Chain: ADD 3+4 -> 7, then chain=1 MUL b=6 -> 42 (16'h002A).
//  5 Backpressure: out_ready=0, stream commands -> exactly DEPTH+1=5 accepted and
//    in_ready=0. out_data held stable. Release out_ready -> 5 results emitted in order.
//  6 Reset mid-op: rst_n=0 while in HOLD with 3 queued -> out_valid=0 immediately,
//    busy=0. After release, no stale result appears.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared alu opcodes plus sequencer command and state types
package alu_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_XOR = 2'd3
  } opcode_e;

  // One queued command; chain=1 replaces operand a with the previous result's low byte
  typedef struct packed {
    opcode_e    op;
    logic [7:0] a;
    logic [7:0] b;
    logic       chain;
  } alu_cmd_t;

  typedef enum logic [1:0] {
    SEQ_IDLE = 2'd0,
    SEQ_EXEC = 2'd1,
    SEQ_HOLD = 2'd2
  } seq_state_e;

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - combinational 8-bit alu with 16-bit result
import alu_pkg::*;

module alu (
  input  opcode_e     op,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] result
);

  // Operands are zero-extended so SUB wraps in 16 bits and MUL keeps the full product
  always_comb begin
    result = 16'd0;
    case (op)
      OP_ADD:  result = {8'd0, a} + {8'd0, b};
      OP_SUB:  result = {8'd0, a} - {8'd0, b};
      OP_MUL:  result = {8'd0, a} * {8'd0, b};
      OP_XOR:  result = {8'd0, a ^ b};
      default: result = 16'd0;
    endcase
  end

endmodule

// File: rtl/alu_cmd_fifo.sv
// rtl/alu_cmd_fifo.sv - synchronous command FIFO with occupancy count
module alu_cmd_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  T                       push_data,
  input  logic                   pop,
  output T                       pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  T                mem_q [DEPTH];
  T                mem_d [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            do_push, do_pop;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];

  // Push is gated only by full, so a pop in the same cycle never frees room for a push
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Next-state for storage, pointers (wrap naturally, DEPTH is a power of 2) and count
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers; reset discards all queued entries
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - queues alu commands and issues them one at a time
import alu_pkg::*;

module alu_cmd_sequencer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  opcode_e     in_op,
  input  logic [7:0]  in_a,
  input  logic [7:0]  in_b,
  input  logic        in_chain,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output opcode_e     alu_op,
  input  logic [15:0] alu_result,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output opcode_e     out_op,
  output logic        busy
);

  alu_cmd_t              push_cmd, head;
  logic                  fifo_full, fifo_empty, pop;
  logic [$clog2(DEPTH):0] fifo_count;

  seq_state_e  state_q, state_d;
  logic [7:0]  alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  opcode_e     alu_op_q, alu_op_d, out_op_q, out_op_d;
  logic        out_valid_q, out_valid_d;
  logic [15:0] out_data_q, out_data_d, last_result_q, last_result_d;

  assign push_cmd = '{op: in_op, a: in_a, b: in_b, chain: in_chain};

  alu_cmd_fifo #(.DEPTH(DEPTH), .T(alu_cmd_t)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (in_valid),
    .push_data (push_cmd),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign in_ready  = !fifo_full;
  assign busy      = (fifo_count != '0) || (state_q != SEQ_IDLE);
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_op    = alu_op_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_op    = out_op_q;

  // Sequencer next-state: issue head, capture alu result, hold until downstream accepts
  always_comb begin
    state_d       = state_q;
    alu_a_d       = alu_a_q;
    alu_b_d       = alu_b_q;
    alu_op_d      = alu_op_q;
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    out_op_d      = out_op_q;
    last_result_d = last_result_q;
    pop           = 1'b0;
    case (state_q)
      SEQ_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = SEQ_EXEC;
        end
      end
      SEQ_EXEC: begin
        out_data_d    = alu_result;
        out_op_d      = alu_op_q;
        last_result_d = alu_result;
        out_valid_d   = 1'b1;
        state_d       = SEQ_HOLD;
      end
      SEQ_HOLD: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = SEQ_EXEC;
          end else begin
            state_d = SEQ_IDLE;
          end
        end
      end
      default: state_d = SEQ_IDLE;
    endcase
    // Chain is resolved at pop time against the result from the preceding EXEC
    if (pop) begin
      alu_a_d  = head.chain ? last_result_q[7:0] : head.a;
      alu_b_d  = head.b;
      alu_op_d = head.op;
    end
  end

  // Single state/output register bank; reset drops any in-flight result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= SEQ_IDLE;
      alu_a_q       <= 8'd0;
      alu_b_q       <= 8'd0;
      alu_op_q      <= OP_ADD;
      out_valid_q   <= 1'b0;
      out_data_q    <= 16'd0;
      out_op_q      <= OP_ADD;
      last_result_q <= 16'd0;
    end else begin
      state_q       <= state_d;
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      alu_op_q      <= alu_op_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_op_q      <= out_op_d;
      last_result_q <= last_result_d;
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb/tb_alu_cmd_sequencer.sv - directed self-checking bench for alu_cmd_sequencer with alu
import alu_pkg::*;

module tb_alu_cmd_sequencer;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  opcode_e     in_op;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic        in_chain;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  opcode_e     alu_op;
  logic [15:0] alu_result;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  opcode_e     out_op;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  alu_cmd_sequencer #(.DEPTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_chain   (in_chain),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_op     (out_op),
    .busy       (busy)
  );

  alu u_alu (
    .op     (alu_op),
    .a      (alu_a),
    .b      (alu_b),
    .result (alu_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input opcode_e op, input logic [7:0] a, input logic [7:0] b, input logic ch);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_chain = ch;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_result(input string tag);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid) begin
        got = 1'b1;
        break;
      end
    end
    check({tag, "_timeout"}, 32'(got), 32'd1);
  endtask

  task automatic run_one(input string tag, input opcode_e op, input logic [7:0] a,
                         input logic [7:0] b, input logic ch, input logic [15:0] exp);
    send(op, a, b, ch);
    wait_result(tag);
    check({tag, "_data"}, 32'(out_data), 32'(exp));
    check({tag, "_op"}, 32'(out_op), 32'(op));
  endtask

  opcode_e     bp_op  [5] = '{OP_ADD, OP_SUB, OP_MUL, OP_XOR, OP_ADD};
  logic [7:0]  bp_a   [5] = '{8'd10, 8'd3, 8'd16, 8'hFF, 8'd255};
  logic [7:0]  bp_b   [5] = '{8'd1, 8'd5, 8'd16, 8'h0F, 8'd255};
  logic [15:0] bp_exp [5] = '{16'h000B, 16'hFFFE, 16'h0100, 16'h00F0, 16'h01FE};

  initial begin
    int acc;
    int got;
    int seen;
    int idx;
    logic rdy;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_op     = OP_ADD;
    in_a      = 8'd0;
    in_b      = 8'd0;
    in_chain  = 1'b0;
    out_ready = 1'b1;

    // Reset state
    tick();
    tick();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_op", 32'(out_op), 32'(OP_ADD));
    check("rst_alu_a", 32'(alu_a), 32'd0);
    rst_n = 1'b1;
    tick();

    // ADD with exact latency: accept at edge N, valid after N+2
    send(OP_ADD, 8'd200, 8'd100, 1'b0);
    check("add_lat_n0", 32'(out_valid), 32'd0);
    tick();
    check("add_lat_n1", 32'(out_valid), 32'd0);
    tick();
    check("add_lat_n2", 32'(out_valid), 32'd1);
    check("add_data", 32'(out_data), 32'h012C);
    check("add_op", 32'(out_op), 32'(OP_ADD));
    tick();
    tick();

    // Each opcode, including 16-bit wrap and full product
    run_one("sub", OP_SUB, 8'd5, 8'd10, 1'b0, 16'hFFFB);
    run_one("mul", OP_MUL, 8'd255, 8'd255, 1'b0, 16'hFE01);
    run_one("xor", OP_XOR, 8'hA5, 8'h0F, 1'b0, 16'h00AA);

    // Chain: second command takes a from the previous result
    run_one("chain0", OP_ADD, 8'd3, 8'd4, 1'b0, 16'h0007);
    run_one("chain1", OP_MUL, 8'd99, 8'd6, 1'b1, 16'h002A);
    tick();
    tick();
    check("idle_busy", 32'(busy), 32'd0);

    // Backpressure: DEPTH queued plus one in flight
    out_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 12; c++) begin
      idx      = (acc < 5) ? acc : 4;
      in_valid = 1'b1;
      in_op    = bp_op[idx];
      in_a     = bp_a[idx];
      in_b     = bp_b[idx];
      in_chain = 1'b0;
      rdy      = in_ready;
      tick();
      if (rdy) acc++;
    end
    in_valid = 1'b0;
    check("bp_accepted", 32'(acc), 32'd5);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    check("bp_valid", 32'(out_valid), 32'd1);
    check("bp_hold0", 32'(out_data), 32'(bp_exp[0]));
    tick();
    tick();
    tick();
    check("bp_hold3", 32'(out_data), 32'(bp_exp[0]));
    check("bp_hold_op", 32'(out_op), 32'(bp_op[0]));

    out_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 30 && got < 5; c++) begin
      if (out_valid) begin
        check($sformatf("bp_data%0d", got), 32'(out_data), 32'(bp_exp[got]));
        check($sformatf("bp_op%0d", got), 32'(out_op), 32'(bp_op[got]));
        got++;
      end
      tick();
    end
    check("bp_count", 32'(got), 32'd5);
    tick();
    tick();
    check("bp_drain_busy", 32'(busy), 32'd0);
    check("bp_drain_ready", 32'(in_ready), 32'd1);

    // Reset while holding a result with three more queued
    out_ready = 1'b0;
    send(OP_ADD, 8'd1, 8'd2, 1'b0);
    send(OP_ADD, 8'd3, 8'd4, 1'b0);
    send(OP_ADD, 8'd5, 8'd6, 1'b0);
    send(OP_ADD, 8'd7, 8'd8, 1'b0);
    got = 0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid) begin
        got = 1;
        break;
      end
      tick();
    end
    check("mid_valid", 32'(got), 32'd1);
    check("mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_ready", 32'(in_ready), 32'd1);
    tick();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid) seen++;
    end
    check("mid_no_stale", 32'(seen), 32'd0);

    // Chain after reset sees a cleared last result
    run_one("post_rst_chain", OP_ADD, 8'd77, 8'd9, 1'b1, 16'h0009);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
